// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: NOOP encoding, fetch FSM states and word-step PC helper.
package fetch_unit_pkg;

  localparam logic [31:0] NOOP_INSTR = 32'h2000_0000;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + 32'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/fetch_unit_timeout_counter.sv
// fetch_timeout_counter: saturating count of WAIT cycles with a sticky timeout flag.
// Latency: flag rises on the edge ending the TIMEOUT_CYCLES-th WAIT cycle; no backpressure.
module fetch_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_wait_i,
  input  logic leave_i,
  output logic timeout_o
);

  localparam int unsigned    CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  CMAX = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          flag_q, flag_d;

  always_comb begin
    cnt_inc = (cnt_q == CMAX) ? cnt_q : cnt_q + CW'(1);
    cnt_d   = '0;
    flag_d  = flag_q;
    if (in_wait_i) begin
      flag_d = flag_q | (cnt_inc == CMAX);
      cnt_d  = leave_i ? '0 : cnt_inc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign timeout_o = flag_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch feeding the FD register; optional FETCH_MISALIGN_TRAP_EN.
// Latency: REQ->WAIT->HOLD, best 1 instr / 3 cycles; backpressure: stall parks HOLD, no new request issues.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] TRAP_VECTOR    = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_value_next,
  output logic [31:0] next_instruction,
  output logic        fd_load_enable,
  output logic        fd_flush,
  output logic        fetch_timeout
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        misalign_fault
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pcn_q, pcn_d;
  logic         kill_q, kill_d;
  logic         valid_q, valid_d;
  logic [31:0]  redir_tgt;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misal_q, misal_d;
  logic redir_misaligned;
  assign redir_misaligned = (redirect_pc[1:0] != 2'b00);
  assign redir_tgt        = redir_misaligned ? TRAP_VECTOR : redirect_pc;
  assign misalign_fault   = misal_q;
`else
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redir_tgt            = {redirect_pc[31:2], 2'b00};
`endif

  assign imem_req         = (state_q == S_REQ);
  assign imem_addr        = pc_q;
  assign next_instruction = instr_q;
  assign pc_value_next    = pcn_q;
  assign fd_load_enable   = valid_q & ~stall & ~redirect;
  assign fd_flush         = redirect;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    instr_d  = instr_q;
    pcn_d    = pcn_q;
    kill_d   = kill_q;
    valid_d  = valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misal_d  = misal_q | (redirect & redir_misaligned);
`endif
    // Redirect outranks stall, gnt and rvalid in every state.
    if (redirect) begin
      pc_d    = redir_tgt;
      valid_d = 1'b0;
    end
    unique case (state_q)
      S_REQ: begin
        if (imem_gnt) begin
          state_d = S_WAIT;
          if (redirect) begin
            kill_d = 1'b1;
          end else begin
            req_pc_d = pc_q;
            pc_d     = next_word(pc_q);
          end
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (redirect || kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d = imem_rdata;
            pcn_d   = next_word(req_pc_q);
            valid_d = 1'b1;
            state_d = S_HOLD;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          state_d = S_REQ;
        end else if (fd_load_enable) begin
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      instr_q  <= NOOP_INSTR;
      pcn_q    <= 32'h0;
      kill_q   <= 1'b0;
      valid_q  <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misal_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      instr_q  <= instr_d;
      pcn_q    <= pcn_d;
      kill_q   <= kill_d;
      valid_q  <= valid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      misal_q  <= misal_d;
`endif
    end
  end

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clk),
    .rst_ni    (rst),
    .in_wait_i (state_q == S_WAIT),
    .leave_i   (state_d != S_WAIT),
    .timeout_o (fetch_timeout)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: hand-computed vectors, immediate assertions, one summary line.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk, rst, stall, redirect, imem_gnt, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, fd_load_enable, fd_flush, fetch_timeout;
  logic [31:0] imem_addr, pc_value_next, next_instruction;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_fault;
`endif

  int nvec = 0;
  int nerr = 0;

  fetch_unit #(
    .RESET_PC      (32'h0000_0000),
    .TIMEOUT_CYCLES(64),
    .TRAP_VECTOR   (32'h0000_0080)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .pc_value_next   (pc_value_next),
    .next_instruction(next_instruction),
    .fd_load_enable  (fd_load_enable),
    .fd_flush        (fd_flush),
    .fetch_timeout   (fetch_timeout)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_fault  (misalign_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Entry: just after an edge with the DUT in REQ; exit: back in REQ after consume.
  task automatic zero_wait(input logic [31:0] addr, input logic [31:0] data, input logic [31:0] exp_pcn);
    chk1("zw_req", imem_req, 1'b1);
    chk ("zw_addr", imem_addr, addr);
    chk1("zw_fle_req", fd_load_enable, 1'b0);
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    chk1("zw_wait_req", imem_req, 1'b0);
    chk1("zw_fle_wait", fd_load_enable, 1'b0);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    cyc();
    imem_rvalid = 1'b0;
    chk1("zw_fle_hold", fd_load_enable, 1'b1);
    chk ("zw_pcn", pc_value_next, exp_pcn);
    chk ("zw_instr", next_instruction, data);
    cyc();
  endtask

  logic [31:0] mis_addr;

  initial begin
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    cyc(); cyc();
    chk1("rst_req", imem_req, 1'b1);
    chk ("rst_addr", imem_addr, 32'h0);
    chk ("rst_instr", next_instruction, 32'h2000_0000);
    chk ("rst_pcn", pc_value_next, 32'h0);
    chk1("rst_fle", fd_load_enable, 1'b0);
    chk1("rst_tmo", fetch_timeout, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk1("rst_mis", misalign_fault, 1'b0);
`endif
    rst = 1'b1;

    // zero-wait stream
    zero_wait(32'h0000_0000, 32'h1111_0000, 32'h0000_0004);
    zero_wait(32'h0000_0004, 32'h1111_0004, 32'h0000_0008);
    zero_wait(32'h0000_0008, 32'h1111_0008, 32'h0000_000C);
    zero_wait(32'h0000_000C, 32'h1111_000C, 32'h0000_0010);

    // stall in HOLD with instruction at PC 0x10
    chk("st_addr", imem_addr, 32'h0000_0010);
    imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h8C01_0004; cyc(); imem_rvalid = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk ("st_instr", next_instruction, 32'h8C01_0004);
      chk ("st_pcn", pc_value_next, 32'h0000_0014);
      chk1("st_fle", fd_load_enable, 1'b0);
      chk1("st_req", imem_req, 1'b0);
      cyc();
    end
    stall = 1'b0;
    #1;
    chk1("st_release_fle", fd_load_enable, 1'b1);
    cyc();
    chk1("st_next_req", imem_req, 1'b1);
    chk ("st_next_addr", imem_addr, 32'h0000_0014);

    // redirect while waiting on 0x20
    zero_wait(32'h0000_0014, 32'h2222_0014, 32'h0000_0018);
    zero_wait(32'h0000_0018, 32'h2222_0018, 32'h0000_001C);
    zero_wait(32'h0000_001C, 32'h2222_001C, 32'h0000_0020);
    chk("rw_addr", imem_addr, 32'h0000_0020);
    imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
    cyc();
    redirect = 1'b1; redirect_pc = 32'h0000_0400;
    #1;
    chk1("rw_flush", fd_flush, 1'b1);
    chk1("rw_fle", fd_load_enable, 1'b0);
    cyc();
    redirect = 1'b0;
    chk1("rw_flush_off", fd_flush, 1'b0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0020; cyc(); imem_rvalid = 1'b0;
    chk1("rw_drop_fle", fd_load_enable, 1'b0);
    chk ("rw_drop_pcn", pc_value_next, 32'h0000_0020);
    zero_wait(32'h0000_0400, 32'h3333_0400, 32'h0000_0404);

    // redirect together with gnt in REQ
    redirect = 1'b1; redirect_pc = 32'h0000_0400; imem_gnt = 1'b1;
    #1;
    chk1("rg_flush", fd_flush, 1'b1);
    cyc();
    redirect = 1'b0; imem_gnt = 1'b0;
    chk1("rg_wait_req", imem_req, 1'b0);
    cyc();
    chk1("rg_fle0", fd_load_enable, 1'b0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0404; cyc(); imem_rvalid = 1'b0;
    chk1("rg_fle1", fd_load_enable, 1'b0);
    chk ("rg_instr", next_instruction, 32'h3333_0400);
    zero_wait(32'h0000_0400, 32'h4444_0400, 32'h0000_0404);

    // misaligned redirect
    redirect = 1'b1; redirect_pc = 32'h0000_0402;
    cyc();
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    mis_addr = 32'h0000_0080;
    chk1("mis_flag", misalign_fault, 1'b1);
`else
    mis_addr = 32'h0000_0400;
`endif
    chk("mis_addr", imem_addr, mis_addr);
    zero_wait(mis_addr, 32'h5555_0000, mis_addr + 32'd4);

    // redirect in HOLD overrides stall, then PC wrap
    imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h6666_0000; cyc(); imem_rvalid = 1'b0;
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #1;
    chk1("rh_flush", fd_flush, 1'b1);
    chk1("rh_fle", fd_load_enable, 1'b0);
    cyc();
    stall = 1'b0; redirect = 1'b0;
    chk1("rh_req", imem_req, 1'b1);
    chk ("rh_addr", imem_addr, 32'hFFFF_FFFC);
    zero_wait(32'hFFFF_FFFC, 32'h7777_FFFC, 32'h0000_0000);
    chk("wrap_addr", imem_addr, 32'h0000_0000);

    // timeout
    imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
    repeat (63) cyc();
    chk1("tmo_63", fetch_timeout, 1'b0);
    cyc();
    chk1("tmo_64", fetch_timeout, 1'b1);
    repeat (5) cyc();
    chk1("tmo_sat", fetch_timeout, 1'b1);
    imem_rvalid = 1'b1; imem_rdata = 32'h8888_0000; cyc(); imem_rvalid = 1'b0;
    chk1("tmo_fle", fd_load_enable, 1'b1);
    chk ("tmo_pcn", pc_value_next, 32'h0000_0004);
    cyc();
    chk1("tmo_sticky", fetch_timeout, 1'b1);
    rst = 1'b0;
    #1;
    chk1("tmo_rst", fetch_timeout, 1'b0);
    chk ("rst2_addr", imem_addr, 32'h0);
    chk ("rst2_instr", next_instruction, 32'h2000_0000);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk1("rst2_mis", misalign_fault, 1'b0);
`endif
    cyc();
    rst = 1'b1;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage pipeline, sitting directly upstream of the fetch/decode pipeline register.
- Owns the PC and issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers one returned instruction and presents it with its PC+4 to the FD register through a load-enable/flush pair.
- Handles branch/jump redirects, including discarding in-flight stale responses.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset.
TIMEOUT_CYCLES, 64, WAIT-state cycle count at which fetch_timeout sets; must be >= 2.
TRAP_VECTOR, 32'h0000_0080, redirect target on misaligned redirect (FETCH_MISALIGN_TRAP_EN only).

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, asynchronous, active-low (0 = in reset)
stall  in  1  hazard unit holds FD register; buffered instruction must not be consumed
redirect  in  1  taken branch/jump from a later stage; one-cycle pulse
redirect_pc  in  32  target PC, valid when redirect=1
imem_req  out  1  fetch request
imem_addr  out  32  fetch byte address, word aligned
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  read data valid; one response per granted request, in order
imem_rdata  in  32  instruction word
pc_value_next  out  32  PC+4 of buffered instruction (to FD register)
next_instruction  out  32  buffered instruction (to FD register)
fd_load_enable  out  1  FD register captures this cycle
fd_flush  out  1  FD register loads NOOP this cycle
fetch_timeout  out  1  sticky: memory failed to respond within TIMEOUT_CYCLES
misalign_fault  out  1  sticky misaligned-redirect flag (FETCH_MISALIGN_TRAP_EN only)

Behaviour:
- Reset (rst=0, async) values:
  - pc=RESET_PC, state=REQ, kill=0, inst_valid=0.
  - next_instruction=NOOP (32'h2000_0000), pc_value_next=0.
  - fetch_timeout=0, misalign_fault=0, wait counter=0.
- Reset may assert in any state. Any in-flight response after reset release is not tracked; the memory must be reset together with this block.
- States:
  - REQ: imem_req=1, imem_addr=pc.
    - gnt -> WAIT; req_pc<=pc; pc<=pc+4.
    - imem_addr is held stable while req=1 and gnt=0.
  - WAIT: imem_req=0; counter increments, saturating at TIMEOUT_CYCLES.
    - Counter reaching TIMEOUT_CYCLES sets fetch_timeout; it remains set until reset.
    - rvalid with kill=1: data dropped; kill<=0; -> REQ.
    - rvalid with kill=0: next_instruction<=imem_rdata; pc_value_next<=req_pc+4; inst_valid<=1; -> HOLD.
    - Counter clears on leaving WAIT.
  - HOLD: imem_req=0; buffered instruction presented to FD.
- Combinational outputs:
  - fd_load_enable = inst_valid & ~stall & ~redirect.
  - fd_flush = redirect.
- Consume: in HOLD with fd_load_enable=1, inst_valid<=0 -> REQ. With stall=1, HOLD persists and outputs are held unchanged.
- Redirect: takes priority over stall, gnt and rvalid. In every state, pc<=redirect_pc and inst_valid<=0.
  - REQ, gnt=0: stay REQ; the next address is the new pc.
  - REQ, gnt=1: -> WAIT with kill=1, because the accepted request is stale.
  - WAIT, rvalid=0: stay WAIT; kill<=1.
  - WAIT, rvalid=1: data dropped; -> REQ.
  - HOLD: -> REQ.
- PC arithmetic: 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- Without FETCH_MISALIGN_TRAP_EN, redirect_pc[1:0] is forced to 2'b00.
- Throughput: 1 instruction per 3 cycles at best (REQ, WAIT, HOLD with zero-wait memory).

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - misalign_fault port exists.
  - A redirect with redirect_pc[1:0]!=0 sets pc<=TRAP_VECTOR instead of redirect_pc, and sets misalign_fault; the flag remains set until reset.
  - All other redirect state effects are unchanged.
- Undefined:
  - misalign_fault port is absent.
  - The low two bits of redirect_pc are masked to 2'b00.

Decomposition:
- Shared cpu package:
  - NOOP_INSTR = 32'h2000_0000 (same constant the FD register uses on flush).
  - Fetch FSM state enum {REQ, WAIT, HOLD}, 2-bit encoding.
  - WORD_BYTES = 4.
- One natural sub-module: fetch_timeout_counter. It implements the saturating WAIT counter and sticky flag, with parameter TIMEOUT_CYCLES and $clog2 width.

Test Plan:
1. Release rst with zero-wait memory (gnt=1, rvalid the cycle after gnt) -> imem_addr sequence 0x0, 0x4, 0x8; fd_load_enable pulses every 3rd cycle; pc_value_next = 0x4, 0x8, 0xC.
2. stall=1 for 5 cycles while in HOLD with instruction 0x8C01_0004 at PC 0x10 -> outputs stable at 0x8C01_0004/0x14, fd_load_enable=0, no imem_req; on stall=0 it loads once, then a request for 0x14 issues.
3. redirect to 0x400 while in WAIT for 0x20 -> fd_flush=1 that cycle; the late 0x20 response is dropped; the next request is 0x400; the next delivery is pc_value_next=0x404.
4. redirect together with gnt in REQ -> WAIT with kill; stale data discarded; no fd_load_enable until the 0x400 response returns.
5. Withhold rvalid for 64 cycles -> fetch_timeout rises and stays 1 after a later rvalid; it clears only on rst=0.
6. With FETCH_MISALIGN_TRAP_EN, redirect_pc=0x402 -> next request at 0x80 and misalign_fault=1. Without the macro -> request at 0x400.
